// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like arbiter slice: transfer sizes and
// master IDs stored in the in-order owner FIFO.
package sram_like_arbiter_pkg;

    typedef logic [1:0] size_t;
    typedef logic       id_t;

    localparam size_t SIZE_BYTE = 2'd0;
    localparam size_t SIZE_HALF = 2'd1;
    localparam size_t SIZE_WORD = 2'd2;

    localparam id_t ID_INST = 1'b0;
    localparam id_t ID_DATA = 1'b1;

    // Round-robin helper: the master that did not win last time.
    function automatic id_t other_id(input id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like port: request/address phase plus in-order completion.
// The master modport issues requests, the slave modport answers them.
interface sram_like_arbiter_if;
    import sram_like_arbiter_pkg::*;

    logic        req;
    logic        wr;
    size_t       size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (output req, wr, size, addr, wdata,
                    input  rdata, addr_ok, data_ok);
    modport slave  (input  req, wr, size, addr, wdata,
                    output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_like_id_fifo.sv
// In-order owner FIFO: one ID bit per accepted-but-unanswered transaction.
// The head entry names the master that receives the next data_ok.
module sram_like_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  id_t  push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output id_t  head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    id_t           mem_r [DEPTH];

    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == {CW{1'b0}});
    assign head  = mem_r[rd_ptr_r];

    // Owner storage and pointers; pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ID_INST;
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_id;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave sram-like arbiter. Address handshakes and data
// responses are passed straight through; the owner FIFO routes in-order
// completions back to the issuing master. A presented but unaccepted request
// locks the grant so req/addr stay stable until addr_ok.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit DATA_PRIO = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_like_arbiter_if.slave         m0,
    sram_like_arbiter_if.slave         m1,
    sram_like_arbiter_if.master        s
);
    id_t  grant_s;
    id_t  head_s;
    logic sel_req_s;
    logic s_req_s;
    logic handshake_s;
    logic pop_s;
    logic full_s;
    logic empty_s;

    logic lock_r;
    id_t  lock_id_r;
    id_t  last_r;

    // Grant selection: a held lock wins, otherwise single requester or tie-break.
    always_comb begin
        grant_s = ID_INST;
        if (lock_r) begin
            grant_s = lock_id_r;
        end else if (m0.req && m1.req) begin
            if (DATA_PRIO) begin
                grant_s = ID_DATA;
            end else begin
                grant_s = other_id(last_r);
            end
        end else if (m1.req) begin
            grant_s = ID_DATA;
        end else begin
            grant_s = ID_INST;
        end
    end

    // Full blocks issue; the pop path is deliberately not used here so that
    // s_data_ok never reaches s_req combinationally.
    assign sel_req_s   = (grant_s == ID_DATA) ? m1.req : m0.req;
    assign s_req_s     = sel_req_s & ~full_s;
    assign handshake_s = s_req_s & s.addr_ok;

    assign s.req   = s_req_s;
    assign s.wr    = (grant_s == ID_DATA) ? m1.wr    : m0.wr;
    assign s.size  = (grant_s == ID_DATA) ? m1.size  : m0.size;
    assign s.addr  = (grant_s == ID_DATA) ? m1.addr  : m0.addr;
    assign s.wdata = (grant_s == ID_DATA) ? m1.wdata : m0.wdata;

    assign m0.addr_ok = handshake_s & (grant_s == ID_INST);
    assign m1.addr_ok = handshake_s & (grant_s == ID_DATA);

    // Responses go to the FIFO head; data_ok with nothing outstanding is dropped.
    assign pop_s      = s.data_ok & ~empty_s;
    assign m0.data_ok = pop_s & (head_s == ID_INST);
    assign m1.data_ok = pop_s & (head_s == ID_DATA);
    assign m0.rdata   = s.rdata;
    assign m1.rdata   = s.rdata;

    // Lock and round-robin history: lock on an unanswered request, release on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_r    <= 1'b0;
            lock_id_r <= ID_INST;
            last_r    <= ID_INST;
        end else if (handshake_s) begin
            lock_r    <= 1'b0;
            last_r    <= grant_s;
        end else if (s_req_s) begin
            lock_r    <= 1'b1;
            lock_id_r <= grant_s;
        end else begin
            lock_r    <= lock_r;
            lock_id_r <= lock_id_r;
        end
    end

    sram_like_id_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (handshake_s),
        .push_id (grant_s),
        .pop     (pop_s),
        .full    (full_s),
        .empty   (empty_s),
        .head    (head_s)
    );
endmodule
